// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: op codes and FSM state encoding.
package ex_pkg;

  localparam logic [4:0] OP_ADDI  = 5'd1;
  localparam logic [4:0] OP_ADD   = 5'd2;
  localparam logic [4:0] OP_SUB   = 5'd3;
  localparam logic [4:0] OP_AND   = 5'd4;
  localparam logic [4:0] OP_OR    = 5'd5;
  localparam logic [4:0] OP_XOR   = 5'd6;
  localparam logic [4:0] OP_SLL   = 5'd7;
  localparam logic [4:0] OP_SRL   = 5'd8;
  localparam logic [4:0] OP_SRA   = 5'd9;
  localparam logic [4:0] OP_SLT   = 5'd10;
  localparam logic [4:0] OP_SLTU  = 5'd11;
  localparam logic [4:0] OP_MUL   = 5'd12;
  localparam logic [4:0] OP_MULHU = 5'd13;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } ex_state_e;

  function automatic logic is_mul_op(input logic [4:0] oh);
    return (oh == OP_MUL) || (oh == OP_MULHU);
  endfunction

endpackage

// File: rtl/ex_mul_iter.sv
// Iterative unsigned XLEN x XLEN -> 2*XLEN radix-2 shift-add multiplier.
// start loads the operands; XLEN steps follow; done pulses for one cycle
// after the final step with the full product held stable on product.
module ex_mul_iter #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic              done,
  output logic [2*XLEN-1:0] product
);

  localparam int CNT_W = $clog2(XLEN);

  logic [XLEN-1:0]   mcand;
  logic [2*XLEN-1:0] prod;
  logic [CNT_W-1:0]  cnt;
  logic              running;
  logic [XLEN:0]     sum;

  // Add the multiplicand into the upper half when the current multiplier bit is set.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    sum = {1'b0, prod[2*XLEN-1:XLEN]};
    if (prod[0]) sum = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, mcand};
  end

  // Step sequencer: abort wins over start; the product shifts right one bit per step.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (rst || abort) begin
      mcand   <= '0;
      prod    <= '0;
      cnt     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else if (start) begin
      mcand   <= a;
      prod    <= {{XLEN{1'b0}}, b};
      cnt     <= '0;
      running <= 1'b1;
      done    <= 1'b0;
    end else if (running) begin
      prod <= {sum, prod[XLEN-1:1]};
      cnt  <= cnt + CNT_W'(1);
      if (cnt == CNT_W'(XLEN - 1)) begin
        running <= 1'b0;
        done    <= 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end

  assign product = prod;

endmodule

// File: rtl/ex_pipe.sv
// Registered RV32I execute stage: single-cycle ALU ops, iterative MUL/MULHU,
// x0 write suppression, valid/ready input handshake with flush.
module ex_pipe
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      oh,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [4:0]      rd_addr2ex,
  input  logic            rd_wen,
  input  logic            flush,
  output logic            out_valid,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] rd_data,
  output logic            rd_wen2reg,
  output logic            busy
);

  localparam int SHAMT_W = $clog2(XLEN);

  ex_state_e         state, state_next;
  logic              accept;
  logic              is_mul;
  logic              mul_start;
  logic              mul_done;
  logic [2*XLEN-1:0] mul_product;
  logic              mul_hi;
  logic [4:0]        mul_rd;
  logic              mul_wen;
  logic [XLEN-1:0]   alu_result;
  logic              alu_known;
  logic [SHAMT_W-1:0] shamt;

  // Readiness depends only on state, never on in_valid.
  assign in_ready  = (state == ST_IDLE);
  assign busy      = ~in_ready;
  assign accept    = in_valid && in_ready && !flush;
  assign is_mul    = is_mul_op(oh);
  assign mul_start = accept && is_mul;
  assign shamt     = op2[SHAMT_W-1:0];

  // Single-cycle ALU; unknown op codes are flagged so they become bubbles.
  always_comb begin
    alu_result = '0;
    alu_known  = 1'b1;
    unique case (oh)
      OP_ADDI, OP_ADD: alu_result = op1 + op2;
      OP_SUB:          alu_result = op1 - op2;
      OP_AND:          alu_result = op1 & op2;
      OP_OR:           alu_result = op1 | op2;
      OP_XOR:          alu_result = op1 ^ op2;
      OP_SLL:          alu_result = op1 << shamt;
      OP_SRL:          alu_result = op1 >> shamt;
      OP_SRA:          alu_result = $signed(op1) >>> shamt;
      OP_SLT:          alu_result = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(op2)};
      OP_SLTU:         alu_result = {{(XLEN-1){1'b0}}, op1 < op2};
      default:         alu_known  = 1'b0;
    endcase
  end

  // Next-state logic: enter MUL on a multiply accept, leave on done; flush forces IDLE.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (mul_start) state_next = ST_MUL;
      ST_MUL:  if (mul_done)  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (flush) state_next = ST_IDLE;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Capture multiply destination and half-select at accept for use at completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_hi  <= 1'b0;
      mul_rd  <= '0;
      mul_wen <= 1'b0;
    end else if (mul_start) begin
      mul_hi  <= (oh == OP_MULHU);
      mul_rd  <= rd_addr2ex;
      mul_wen <= rd_wen;
    end
  end

  ex_mul_iter #(.XLEN(XLEN)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .abort   (flush),
    .a       (op1),
    .b       (op2),
    .done    (mul_done),
    .product (mul_product)
  );

  // Output register: result pulse, x0 suppression; address/data hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      rd_addr    <= '0;
      rd_data    <= '0;
      rd_wen2reg <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      rd_wen2reg <= 1'b0;
    end else if (state == ST_MUL && mul_done) begin
      out_valid  <= 1'b1;
      rd_addr    <= mul_rd;
      rd_data    <= mul_hi ? mul_product[2*XLEN-1:XLEN] : mul_product[XLEN-1:0];
      rd_wen2reg <= mul_wen && (mul_rd != 5'd0);
    end else if (accept && !is_mul) begin
      out_valid <= 1'b1;
      if (alu_known) begin
        rd_addr    <= rd_addr2ex;
        rd_data    <= alu_result;
        rd_wen2reg <= rd_wen && (rd_addr2ex != 5'd0);
      end else begin
        rd_addr    <= '0;
        rd_data    <= '0;
        rd_wen2reg <= 1'b0;
      end
    end else begin
      out_valid  <= 1'b0;
      rd_wen2reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_pipe.sv
// Directed self-checking bench for ex_pipe (XLEN=32).
module tb_ex_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  oh;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [4:0]  rd_addr2ex;
  logic        rd_wen;
  logic        flush;
  logic        out_valid;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_wen2reg;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ex_pipe #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .oh         (oh),
    .op1        (op1),
    .op2        (op2),
    .rd_addr2ex (rd_addr2ex),
    .rd_wen     (rd_wen),
    .flush      (flush),
    .out_valid  (out_valid),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_wen2reg (rd_wen2reg),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge; sample 1 time unit later, away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic wen);
    in_valid   = 1'b1;
    oh         = o;
    op1        = a;
    op2        = b;
    rd_addr2ex = rd;
    rd_wen     = wen;
  endtask

  task automatic check_result(input string tag, input logic [31:0] data, input logic [4:0] addr,
                              input logic wen);
    check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, ".data"}, rd_data, data);
    check({tag, ".addr"}, {27'd0, rd_addr}, {27'd0, addr});
    check({tag, ".wen"}, {31'd0, rd_wen2reg}, {31'd0, wen});
  endtask

  // Step until out_valid, bounded; reports the edge count and whether in_ready ever rose early.
  task automatic wait_result(input string tag, output int cycles);
    int early_ready = 0;
    cycles = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      cycles++;
      if (out_valid) break;
      if (in_ready || !busy) early_ready++;
    end
    check({tag, ".timeout"}, {31'd0, out_valid}, 32'd1);
    check({tag, ".ready_low"}, early_ready, 0);
  endtask

  // Step n edges and confirm no result pulse appears.
  task automatic expect_silence(input string tag, input int n);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (out_valid || rd_wen2reg) seen++;
    end
    check({tag, ".silent"}, seen, 0);
  endtask

  initial begin
    int cycles;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
    oh = '0; op1 = '0; op2 = '0; rd_addr2ex = '0; rd_wen = 1'b0;
    step(); step();
    check("rst.valid", {31'd0, out_valid}, 0);
    check("rst.addr", {27'd0, rd_addr}, 0);
    check("rst.data", rd_data, 0);
    check("rst.wen", {31'd0, rd_wen2reg}, 0);
    check("rst.ready", {31'd0, in_ready}, 1);
    check("rst.busy", {31'd0, busy}, 0);
    rst = 1'b0;

    // Back-to-back single-cycle ops, one result per cycle.
    drive(5'd2, 32'd5, 32'd7, 5'd3, 1'b1);                   step(); check_result("add", 32'd12, 5'd3, 1'b1);
    drive(5'd3, 32'd3, 32'd5, 5'd4, 1'b1);                   step(); check_result("sub", 32'hFFFF_FFFE, 5'd4, 1'b1);
    drive(5'd9, 32'h8000_0000, 32'd4, 5'd5, 1'b1);           step(); check_result("sra", 32'hF800_0000, 5'd5, 1'b1);
    drive(5'd8, 32'h8000_0000, 32'd4, 5'd6, 1'b1);           step(); check_result("srl", 32'h0800_0000, 5'd6, 1'b1);
    drive(5'd7, 32'd1, 32'd35, 5'd7, 1'b1);                  step(); check_result("sll", 32'h0000_0008, 5'd7, 1'b1);
    drive(5'd10, 32'hFFFF_FFFF, 32'd1, 5'd8, 1'b1);          step(); check_result("slt", 32'd1, 5'd8, 1'b1);
    drive(5'd11, 32'hFFFF_FFFF, 32'd1, 5'd9, 1'b1);          step(); check_result("sltu", 32'd0, 5'd9, 1'b1);
    drive(5'd4, 32'h0000_F0F0, 32'h0000_FF00, 5'd10, 1'b1);  step(); check_result("and", 32'h0000_F000, 5'd10, 1'b1);
    drive(5'd5, 32'h0000_F0F0, 32'h0000_FF00, 5'd11, 1'b1);  step(); check_result("or", 32'h0000_FFF0, 5'd11, 1'b1);
    drive(5'd6, 32'h0000_F0F0, 32'h0000_FF00, 5'd12, 1'b1);  step(); check_result("xor", 32'h0000_0FF0, 5'd12, 1'b1);
    drive(5'd1, 32'hFFFF_FFFF, 32'd1, 5'd13, 1'b1);          step(); check_result("addi_wrap", 32'd0, 5'd13, 1'b1);
    check("alu.ready", {31'd0, in_ready}, 1);

    // Idle cycle: pulse drops, address/data hold.
    in_valid = 1'b0; step();
    check("idle.valid", {31'd0, out_valid}, 0);
    check("idle.wen", {31'd0, rd_wen2reg}, 0);
    check("idle.data_hold", rd_data, 32'd0);
    check("idle.addr_hold", {27'd0, rd_addr}, 32'd13);

    // MUL with an ADD held by the source during busy.
    drive(5'd12, 32'hFFFF_FFFF, 32'd2, 5'd14, 1'b1); step();
    check("mul.busy", {31'd0, busy}, 1);
    check("mul.ready", {31'd0, in_ready}, 0);
    drive(5'd2, 32'd1, 32'd1, 5'd15, 1'b1);
    wait_result("mul", cycles);
    check("mul.latency", cycles, 33);
    check_result("mul", 32'hFFFF_FFFE, 5'd14, 1'b1);
    check("mul.ready_back", {31'd0, in_ready}, 1);
    step();
    check_result("held_add", 32'd2, 5'd15, 1'b1);

    drive(5'd13, 32'hFFFF_FFFF, 32'd2, 5'd16, 1'b1); step();
    in_valid = 1'b0;
    wait_result("mulhu", cycles);
    check("mulhu.latency", cycles, 33);
    check_result("mulhu", 32'd1, 5'd16, 1'b1);

    // x0 suppression, disabled write, unknown op bubble.
    drive(5'd2, 32'd2, 32'd3, 5'd0, 1'b1);   step(); check_result("x0", 32'd5, 5'd0, 1'b0);
    drive(5'd2, 32'd4, 32'd4, 5'd8, 1'b0);   step(); check_result("nowen", 32'd8, 5'd8, 1'b0);
    drive(5'd20, 32'd9, 32'd9, 5'd7, 1'b1);  step(); check_result("bubble", 32'd0, 5'd0, 1'b0);

    // Flush with an instruction offered in idle: not accepted.
    drive(5'd2, 32'd1, 32'd2, 5'd3, 1'b1); flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_idle.valid", {31'd0, out_valid}, 0);
    check("flush_idle.wen", {31'd0, rd_wen2reg}, 0);

    // Flush mid-MUL, then a normal ADD.
    drive(5'd12, 32'd3, 32'd4, 5'd3, 1'b1); step();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) step();
    flush = 1'b1; step(); flush = 1'b0;
    check("flush_mul.valid", {31'd0, out_valid}, 0);
    check("flush_mul.ready", {31'd0, in_ready}, 1);
    expect_silence("flush_mul", 40);
    drive(5'd2, 32'd10, 32'd20, 5'd9, 1'b1); step(); in_valid = 1'b0;
    check_result("post_flush_add", 32'd30, 5'd9, 1'b1);

    // Flush coinciding with the MUL completion edge discards the result.
    drive(5'd12, 32'd3, 32'd4, 5'd3, 1'b1); step();
    in_valid = 1'b0;
    for (int i = 0; i < 32; i++) step();
    check("late_flush.pre_valid", {31'd0, out_valid}, 0);
    flush = 1'b1; step(); flush = 1'b0;
    check("late_flush.valid", {31'd0, out_valid}, 0);
    check("late_flush.ready", {31'd0, in_ready}, 1);
    expect_silence("late_flush", 40);

    // Reset mid-MUL returns everything to reset values; no stale result.
    drive(5'd12, 32'd6, 32'd7, 5'd4, 1'b1); step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1; step(); rst = 1'b0;
    check("rst_mul.valid", {31'd0, out_valid}, 0);
    check("rst_mul.addr", {27'd0, rd_addr}, 0);
    check("rst_mul.data", rd_data, 0);
    check("rst_mul.wen", {31'd0, rd_wen2reg}, 0);
    check("rst_mul.ready", {31'd0, in_ready}, 1);
    check("rst_mul.busy", {31'd0, busy}, 0);
    expect_silence("rst_mul", 40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
